// File: rtl/sent_tx_slow_sched_if.sv
// Bundle between the SENT slow-channel scheduler and its environment:
// the requester side, the transmitter's frame strobe, and the latched message fields.
interface sent_tx_slow_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [1:0]            channel_format_i;
    logic                  frame_done_i;
    logic [NUM_REQ-1:0]    req_i;
    logic [8*NUM_REQ-1:0]  req_id_i;
    logic [16*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_config_i;

    logic [NUM_REQ-1:0]    grant_o;
    logic [NUM_REQ-1:0]    done_o;
    logic                  enable_o;
    logic [7:0]            id_o;
    logic [15:0]           data_bit_field_o;
    logic                  config_bit_o;
    logic [4:0]            frame_cnt_o;
    logic                  busy_o;

    modport master (
        output channel_format_i, frame_done_i, req_i, req_id_i, req_data_i, req_config_i,
        input  grant_o, done_o, enable_o, id_o, data_bit_field_o, config_bit_o,
               frame_cnt_o, busy_o
    );

    modport slave (
        input  channel_format_i, frame_done_i, req_i, req_id_i, req_data_i, req_config_i,
        output grant_o, done_o, enable_o, id_o, data_bit_field_o, config_bit_o,
               frame_cnt_o, busy_o
    );
endinterface

// File: rtl/sent_tx_slow_sched.sv
// Round-robin scheduler for the SENT slow (serial) channel: latches one requester's
// message and holds it for exactly 16 or 18 fast frames, then hands over on the frame boundary.
module sent_tx_slow_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                clk_tx,
    input  logic                reset_tx,
    sent_tx_slow_sched_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               enable_q;
    logic               config_q;
    logic               lenLong_q;
    logic [7:0]         id_q;
    logic [15:0]        data_q;
    logic [4:0]         frameCnt_q;

    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   rrIdx;
    logic [NUM_REQ-1:0] winnerHot;
    logic [NUM_REQ-1:0] ownerHot;
    logic               found;
    logic               arbitrate;
    logic               lastFrame;
    logic               frameEnd;
    logic               doLatch;
    int                 rrSum;

    // Search starts at the pointer and wraps, so the previous winner is considered last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rrSum  = 0;
        rrIdx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rrSum = int'(ptr_q) + i;
            if (rrSum >= NUM_REQ) begin
                rrSum = rrSum - NUM_REQ;
            end
            rrIdx = PTR_W'(rrSum);
            if (!found && bus.req_i[rrIdx]) begin
                found  = 1'b1;
                winner = rrIdx;
            end
        end
    end

    always_comb begin
        winnerHot         = '0;
        winnerHot[winner] = 1'b1;
        ownerHot          = '0;
        ownerHot[owner_q] = 1'b1;
    end

    assign ptr_d     = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign arbitrate = ~bus.channel_format_i[1] & found;
    assign lastFrame = (frameCnt_q == (lenLong_q ? 5'd17 : 5'd15));
    assign frameEnd  = (state_q == SEND) & bus.frame_done_i & lastFrame;
    assign doLatch   = arbitrate & ((state_q == IDLE) | frameEnd);

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            enable_q   <= 1'b0;
            config_q   <= 1'b0;
            lenLong_q  <= 1'b0;
            id_q       <= '0;
            data_q     <= '0;
            frameCnt_q <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (arbitrate) begin
                        state_q <= WAIT;
                    end
                end
                // A frame strobe coinciding with the grant pulse belongs to a frame
                // that began before the message was latched, so it cannot start it.
                WAIT: begin
                    if (bus.frame_done_i && !(|grant_q)) begin
                        enable_q   <= 1'b1;
                        frameCnt_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (bus.frame_done_i) begin
                        if (lastFrame) begin
                            done_q     <= ownerHot;
                            frameCnt_q <= '0;
                            if (!arbitrate) begin
                                enable_q <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end else begin
                            frameCnt_q <= frameCnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (doLatch) begin
                grant_q   <= winnerHot;
                owner_q   <= winner;
                ptr_q     <= ptr_d;
                id_q      <= bus.req_id_i[8*winner +: 8];
                data_q    <= bus.req_data_i[16*winner +: 16];
                config_q  <= bus.req_config_i[winner];
                lenLong_q <= bus.channel_format_i[0];
            end
        end
    end

    assign bus.grant_o          = grant_q;
    assign bus.done_o           = done_q;
    assign bus.enable_o         = enable_q;
    assign bus.id_o             = id_q;
    assign bus.data_bit_field_o = data_q;
    assign bus.config_bit_o     = config_q;
    assign bus.frame_cnt_o      = frameCnt_q;
    assign bus.busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_sent_tx_slow_sched.sv
// Bench for the SENT slow-channel scheduler: directed scenarios plus randomized
// message sequences, checked against a message-level round-robin model.
module tb_sent_tx_slow_sched;

    localparam int NUM_REQ = 4;

    logic clk_tx   = 1'b0;
    logic reset_tx = 1'b1;

    always #5 clk_tx = ~clk_tx;

    sent_tx_slow_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    sent_tx_slow_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk_tx   (clk_tx),
        .reset_tx (reset_tx),
        .bus      (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  idArr   [NUM_REQ];
    logic [15:0] dataArr [NUM_REQ];
    logic        cfgArr  [NUM_REQ];
    int          mPtr   = 0;
    int          owner  = 0;
    int          len    = 16;
    int          expCnt = 0;
    logic [7:0]  expId;
    logic [15:0] expData;
    logic        expCfg;
    bit          inSend = 1'b0;

    function automatic logic [NUM_REQ-1:0] oneHot(input int w);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    function automatic int rrPick(input logic [NUM_REQ-1:0] m, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic applyStimulus(input logic fd, input logic [NUM_REQ-1:0] req, input logic [1:0] fmt);
        bus.frame_done_i     = fd;
        bus.req_i            = req;
        bus.channel_format_i = fmt;
    endtask

    task automatic driveFields();
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_id_i[8*k +: 8]    = idArr[k];
            bus.req_data_i[16*k +: 16] = dataArr[k];
            bus.req_config_i[k]       = cfgArr[k];
        end
    endtask

    task automatic randomizeFields();
        for (int k = 0; k < NUM_REQ; k++) begin
            idArr[k]   = 8'($urandom);
            dataArr[k] = 16'($urandom);
            cfgArr[k]  = 1'($urandom);
        end
        driveFields();
    endtask

    // Message-level model: what the winner's fields are at the moment of arbitration.
    task automatic latchModel(input int w, input logic [1:0] fmt);
        expId   = idArr[w];
        expData = dataArr[w];
        expCfg  = cfgArr[w];
        owner   = w;
        len     = fmt[0] ? 18 : 16;
        mPtr    = (w + 1) % NUM_REQ;
        expCnt  = 0;
    endtask

    task automatic checkLatched(input string tag);
        checkOutput({tag, "Id"}, bus.id_o, expId);
        checkOutput({tag, "Data"}, bus.data_bit_field_o, expData);
        checkOutput({tag, "Cfg"}, bus.config_bit_o, expCfg);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "Grant"}, bus.grant_o, 0);
        checkOutput({tag, "Done"}, bus.done_o, 0);
        checkOutput({tag, "Enable"}, bus.enable_o, 0);
        checkOutput({tag, "Busy"}, bus.busy_o, 0);
        checkOutput({tag, "Cnt"}, bus.frame_cnt_o, 0);
    endtask

    task automatic doReset();
        reset_tx = 1'b1;
        applyStimulus(1'b0, '0, 2'd0);
        tick();
        tick();
        reset_tx = 1'b0;
        mPtr     = 0;
        inSend   = 1'b0;
    endtask

    // From IDLE: grant, ignored strobe during the grant cycle, then the starting strobe.
    task automatic startMessage(input logic [NUM_REQ-1:0] mask, input logic [1:0] fmt);
        int w;
        applyStimulus(1'b0, mask, fmt);
        tick();
        w = rrPick(mask, mPtr);
        latchModel(w, fmt);
        checkOutput("grant", bus.grant_o, oneHot(w));
        checkLatched("grant");
        checkOutput("busyWait", bus.busy_o, 1);
        checkOutput("enableWait", bus.enable_o, 0);
        bus.frame_done_i = 1'b1;
        tick();
        bus.frame_done_i = 1'b0;
        checkOutput("enableIgnored", bus.enable_o, 0);
        checkOutput("grantOnce", bus.grant_o, 0);
        repeat ($urandom_range(0, 3)) tick();
        bus.frame_done_i = 1'b1;
        tick();
        bus.frame_done_i = 1'b0;
        checkOutput("enableStart", bus.enable_o, 1);
        checkOutput("cntStart", bus.frame_cnt_o, 0);
        checkOutput("doneStart", bus.done_o, 0);
        inSend = 1'b1;
    endtask

    task automatic sendPulses(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                checkOutput("doneGap", bus.done_o, 0);
            end
            if (k == n / 2) begin
                randomizeFields();
                bus.req_i            = NUM_REQ'($urandom);
                bus.channel_format_i = 2'($urandom);
            end
            bus.frame_done_i = 1'b1;
            tick();
            bus.frame_done_i = 1'b0;
            expCnt++;
            checkOutput("frameCnt", bus.frame_cnt_o, expCnt);
            checkOutput("doneEarly", bus.done_o, 0);
            checkOutput("enableHeld", bus.enable_o, 1);
            checkOutput("grantMid", bus.grant_o, 0);
            checkLatched("stable");
        end
    endtask

    task automatic finishMessage(input logic [NUM_REQ-1:0] mask, input logic [1:0] fmt);
        int w;
        applyStimulus(1'b1, mask, fmt);
        tick();
        bus.frame_done_i = 1'b0;
        checkOutput("done", bus.done_o, oneHot(owner));
        checkOutput("cntWrap", bus.frame_cnt_o, 0);
        if (!fmt[1] && mask != '0) begin
            w = rrPick(mask, mPtr);
            latchModel(w, fmt);
            checkOutput("grantB2B", bus.grant_o, oneHot(w));
            checkLatched("rearb");
            checkOutput("enableB2B", bus.enable_o, 1);
            inSend = 1'b1;
        end else begin
            checkOutput("grantEnd", bus.grant_o, 0);
            checkOutput("enableEnd", bus.enable_o, 0);
            checkOutput("busyEnd", bus.busy_o, 0);
            inSend = 1'b0;
        end
        tick();
        checkOutput("doneOnce", bus.done_o, 0);
        checkOutput("grantAfter", bus.grant_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, '0, 2'd1);
        randomizeFields();
        reset_tx = 1'b1;
        repeat (3) tick();
        reset_tx = 1'b0;
        checkIdle("reset");
        checkOutput("resetId", bus.id_o, 0);
        checkOutput("resetData", bus.data_bit_field_o, 0);
        checkOutput("resetCfg", bus.config_bit_o, 0);

        $display("[TB] single enhanced message");
        idArr[1]   = 8'h5A;
        dataArr[1] = 16'hBEEF;
        driveFields();
        startMessage(4'b0010, 2'd1);
        sendPulses(len - 1);
        finishMessage('0, 2'd1);
        repeat (3) tick();
        checkIdle("afterSingle");

        $display("[TB] all four requesters back to back");
        doReset();
        startMessage(4'b1111, 2'd1);
        checkOutput("firstOwner", owner, 0);
        for (int m = 0; m < 3; m++) begin
            sendPulses(len - 1);
            finishMessage(4'b1111, 2'd1);
        end
        checkOutput("lastOwner", owner, 3);
        sendPulses(len - 1);
        finishMessage('0, 2'd1);

        $display("[TB] short serial");
        startMessage(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 2'd0);
        sendPulses(len - 1);
        finishMessage('0, 2'd0);

        $display("[TB] disabled format");
        applyStimulus(1'b0, 4'b1111, 2'd2);
        for (int c = 0; c < 100; c++) begin
            bus.frame_done_i = 1'($urandom);
            tick();
            checkOutput("disGrant", bus.grant_o, 0);
            checkOutput("disEnable", bus.enable_o, 0);
            checkOutput("disBusy", bus.busy_o, 0);
        end
        bus.frame_done_i = 1'b0;

        $display("[TB] reset mid-message");
        startMessage(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 2'd1);
        sendPulses(7);
        checkOutput("cntBeforeReset", bus.frame_cnt_o, 7);
        reset_tx = 1'b1;
        applyStimulus(1'b0, '0, 2'd1);
        tick();
        reset_tx = 1'b0;
        mPtr     = 0;
        checkIdle("midReset");
        checkOutput("midResetId", bus.id_o, 0);
        checkOutput("midResetData", bus.data_bit_field_o, 0);
        tick();
        checkOutput("noAbortDone", bus.done_o, 0);
        startMessage(4'b1111, 2'd1);
        checkOutput("ownerAfterReset", owner, 0);
        sendPulses(len - 1);
        finishMessage('0, 2'd1);

        $display("[TB] randomized message sequence");
        for (int r = 0; r < 12; r++) begin
            if (!inSend) begin
                randomizeFields();
                startMessage(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 2'($urandom_range(0, 1)));
            end
            sendPulses(len - 1);
            finishMessage(NUM_REQ'($urandom), 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
